ar_rx_word: RTL and testbench
=============================

Name: ar_rx_word

Overview:
ARINC-429 word-level receiver. It is the receive-side counterpart of the AR_TXA transmitter. It consumes the bipolar RZ comparator outputs RXP/RXN, samples them on the ce_tact tick, and validates pulse/null timing. It assembles 32-bit words and delivers each with a parity flag, a one-clock strobe, a word counter and coded error pulses for the LED/display path.

Parameters:
W_MIN, 2, minimum valid pulse width in ce ticks
W_MAX, 6, maximum valid pulse width in ce ticks
NULL_MIN, 2, minimum null between bits in ce ticks
GAP_MIN, 24, null length in ce ticks that qualifies an inter-word gap
LABEL, 8'h00, accepted label (used only with AR_LABEL_FILT_EN)

Ports:
clk  in  1  system clock, 50 MHz via BUFG
res_n  in  1  asynchronous active-low reset
ce  in  1  sampling tick, 8x bit rate (800 kHz for 100 kbit/s); one clk wide
RXP  in  1  positive-level comparator output, asynchronous
RXN  in  1  negative-level comparator output, asynchronous
dat  out  32  last delivered word; first received bit in dat[0]
ce_wr  out  1  one-clk strobe: dat/par_ok valid
par_ok  out  1  1 = odd parity over dat[31:0]
N_word  out  8  delivered-word counter
err  out  1  one-clk error strobe
err_code  out  3  code of last error; holds until next error

Behaviour:
- Reset (res_n=0, async): dat=0, ce_wr=0, par_ok=0, N_word=0, err=0, err_code=0, state=SYNC, all counters 0.
- RXP/RXN pass through a 2-FF synchronizer every clk. All timing counters advance only when ce=1. State decisions are made on ce cycles; outputs are registered.
- Line levels per ce sample: NULL = both 0, HI = RXP only, LO = RXN only, BOTH = both 1.
- SYNC: count consecutive NULL ticks. Any non-NULL sample clears the count. When the count reaches GAP_MIN, go to NULLW with bit count k=0.
- NULLW: null counter runs, saturating at GAP_MIN.
  - HI/LO with null count >= NULL_MIN: latch polarity (HI=1, LO=0), width=1, go to PULSE.
  - HI/LO with null count < NULL_MIN: error 3 (short null), go to SYNC.
  - Null count reaches GAP_MIN with k in 1..31: error 4 (truncated word), k=0, stay in NULLW.
  - BOTH: error 1, go to SYNC.
- PULSE:
  - Same polarity: width+1. If width exceeds W_MAX: error 5 (stuck), go to SYNC.
  - NULL with width >= W_MIN: shift bit in (sr <= {bit, sr[31:1]}), k+1, null count=1, go to NULLW.
  - NULL with width < W_MIN: error 2 (glitch), go to SYNC.
  - Opposite polarity or BOTH: error 1, go to SYNC.
- Word completion: when k reaches 32, on the next clk load dat=sr, set par_ok = XOR of sr, pulse ce_wr for 1 clk, and increment N_word (255 wraps to 0). Then k=0, and the state is NULLW with a gap requirement.
- Gap requirement: after a word, the first HI/LO before GAP_MIN null ticks gives error 6 (no gap) and goes to SYNC. The already delivered word stands.
- err is a 1-clk pulse coincident with the err_code update. Simultaneous word completion and error cannot occur; ce_wr has priority by construction.
- Any error discards the partial word; dat keeps its previous value.
- Reset mid-word: partial word lost; receiver waits for a full gap before accepting bits.

Optional Feature:
Macro AR_LABEL_FILT_EN.
- Defined: a completed word with sr[7:0] != LABEL is silently dropped. There is no ce_wr, no N_word increment and no dat update; the gap requirement still applies.
- Undefined: every completed word is delivered and the LABEL parameter is unused.

Test Plan:
- Reset, 24-tick null, then word 0x800000A5 with 4-tick pulses and 4-tick nulls, then 32-tick gap -> ce_wr once, dat=0x800000A5, par_ok=1, N_word=1, err never.
- Word 0x000000A5 -> dat=0x000000A5, par_ok=0, N_word increments.
- 10 bits then 30-tick null -> err pulse, err_code=4, no ce_wr, dat unchanged; following full word is received correctly.
- Mid-word HI lasting 1 tick -> err_code=2; RXP and RXN both high -> err_code=1; HI held 8 ticks -> err_code=5; null of 1 tick -> err_code=3.
- Two words separated by 8-tick null -> first delivered, err_code=6, second discarded.
- With AR_LABEL_FILT_EN and LABEL=8'hA5: words 0x000000A5 then 0x0000005A -> one ce_wr (0x000000A5), N_word=1.

Source files
------------

// File: rtl/ar_rx_word.sv
// ARINC-429 word receiver: validates RZ pulse/null timing on RXP/RXN and assembles 32-bit words.
// Optional label filter enabled by defining AR_LABEL_FILT_EN.
module ar_rx_word #(
  parameter int unsigned W_MIN    = 2,
  parameter int unsigned W_MAX    = 6,
  parameter int unsigned NULL_MIN = 2,
  parameter int unsigned GAP_MIN  = 24,
  parameter logic [7:0]  LABEL    = 8'h00
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        ce,
  input  logic        RXP,
  input  logic        RXN,
  output logic [31:0] dat,
  output logic        ce_wr,
  output logic        par_ok,
  output logic [7:0]  N_word,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam int unsigned CW = $clog2(GAP_MIN + 1);
  localparam int unsigned WW = $clog2(W_MAX + 1);

  localparam logic [CW-1:0] GAP_C  = CW'(GAP_MIN);
  localparam logic [CW-1:0] NULL_C = CW'(NULL_MIN);
  localparam logic [WW-1:0] WMIN_C = WW'(W_MIN);
  localparam logic [WW-1:0] WMAX_C = WW'(W_MAX);

  localparam logic [1:0] S_SYNC  = 2'd0;
  localparam logic [1:0] S_NULLW = 2'd1;
  localparam logic [1:0] S_PULSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic          rxp_s1_q, rxp_s2_q, rxn_s1_q, rxn_s2_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wid_q, wid_d;
  logic [5:0]    k_q, k_d;
  logic [31:0]   sr_q, sr_d;
  logic          pol_q, pol_d;
  logic          gap_q, gap_d;
  logic [31:0]   dat_q, dat_d;
  logic          ce_wr_q, ce_wr_d;
  logic          par_q, par_d;
  logic [7:0]    nword_q, nword_d;
  logic          err_q, err_d;
  logic [2:0]    code_q, code_d;

  logic lv_null, lv_hi, lv_lo, lv_both, lv_pulse;
  logic fault;
  logic [2:0] fault_code;
  logic keep;

  assign lv_null  = ~rxp_s2_q & ~rxn_s2_q;
  assign lv_hi    =  rxp_s2_q & ~rxn_s2_q;
  assign lv_lo    = ~rxp_s2_q &  rxn_s2_q;
  assign lv_both  =  rxp_s2_q &  rxn_s2_q;
  assign lv_pulse = lv_hi | lv_lo;

`ifdef AR_LABEL_FILT_EN
  assign keep = (sr_q[7:0] == LABEL);
`else
  logic unused_label;
  assign keep = 1'b1;
  assign unused_label = ^LABEL;
`endif

  // Next-state and output decode; all decisions on ce, delivery one clk after the 32nd bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wid_d      = wid_q;
    k_d        = k_q;
    sr_d       = sr_q;
    pol_d      = pol_q;
    gap_d      = gap_q;
    dat_d      = dat_q;
    ce_wr_d    = 1'b0;
    par_d      = par_q;
    nword_d    = nword_q;
    err_d      = 1'b0;
    code_d     = code_q;
    fault      = 1'b0;
    fault_code = 3'd0;

    case (state_q)
      S_SYNC: begin
        if (ce) begin
          if (!lv_null) begin
            cnt_d = '0;
          end else if (cnt_q == GAP_C - CW'(1)) begin
            state_d = S_NULLW;
            cnt_d   = GAP_C;
            k_d     = 6'd0;
            gap_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_NULLW: begin
        if (ce) begin
          if (lv_null) begin
            if (cnt_q != GAP_C) begin
              cnt_d = cnt_q + CW'(1);
              // Reaching a full gap satisfies the inter-word gap and aborts a partial word.
              if (cnt_q == GAP_C - CW'(1)) begin
                gap_d = 1'b0;
                if (k_q != 6'd0) begin
                  k_d    = 6'd0;
                  err_d  = 1'b1;
                  code_d = 3'd4;
                end
              end
            end
          end else if (lv_both) begin
            fault = 1'b1; fault_code = 3'd1;
          end else if (gap_q) begin
            fault = 1'b1; fault_code = 3'd6;
          end else if (cnt_q < NULL_C) begin
            fault = 1'b1; fault_code = 3'd3;
          end else begin
            pol_d   = lv_hi;
            wid_d   = WW'(1);
            state_d = S_PULSE;
          end
        end
      end
      S_PULSE: begin
        if (ce) begin
          if (lv_both || (lv_pulse && (lv_hi != pol_q))) begin
            fault = 1'b1; fault_code = 3'd1;
          end else if (lv_pulse) begin
            if (wid_q == WMAX_C) begin
              fault = 1'b1; fault_code = 3'd5;
            end else begin
              wid_d = wid_q + WW'(1);
            end
          end else if (wid_q < WMIN_C) begin
            fault = 1'b1; fault_code = 3'd2;
          end else begin
            sr_d    = {pol_q, sr_q[31:1]};
            k_d     = k_q + 6'd1;
            cnt_d   = CW'(1);
            state_d = (k_q == 6'd31) ? S_DONE : S_NULLW;
          end
        end
      end
      default: begin
        if (keep) begin
          dat_d   = sr_q;
          par_d   = ^sr_q;
          ce_wr_d = 1'b1;
          nword_d = nword_q + 8'd1;
        end
        k_d     = 6'd0;
        gap_d   = 1'b1;
        state_d = S_NULLW;
        if (ce && lv_null && (cnt_q != GAP_C)) cnt_d = cnt_q + CW'(1);
      end
    endcase

    // Any timing violation drops the partial word and resynchronises on a full gap.
    if (fault) begin
      err_d   = 1'b1;
      code_d  = fault_code;
      state_d = S_SYNC;
      cnt_d   = '0;
      k_d     = 6'd0;
      gap_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rxp_s1_q <= 1'b0;
      rxp_s2_q <= 1'b0;
      rxn_s1_q <= 1'b0;
      rxn_s2_q <= 1'b0;
      state_q  <= S_SYNC;
      cnt_q    <= '0;
      wid_q    <= '0;
      k_q      <= 6'd0;
      sr_q     <= 32'd0;
      pol_q    <= 1'b0;
      gap_q    <= 1'b0;
      dat_q    <= 32'd0;
      ce_wr_q  <= 1'b0;
      par_q    <= 1'b0;
      nword_q  <= 8'd0;
      err_q    <= 1'b0;
      code_q   <= 3'd0;
    end else begin
      rxp_s1_q <= RXP;
      rxp_s2_q <= rxp_s1_q;
      rxn_s1_q <= RXN;
      rxn_s2_q <= rxn_s1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wid_q    <= wid_d;
      k_q      <= k_d;
      sr_q     <= sr_d;
      pol_q    <= pol_d;
      gap_q    <= gap_d;
      dat_q    <= dat_d;
      ce_wr_q  <= ce_wr_d;
      par_q    <= par_d;
      nword_q  <= nword_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  assign dat      = dat_q;
  assign ce_wr    = ce_wr_q;
  assign par_ok   = par_q;
  assign N_word   = nword_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_ar_rx_word.sv
// Directed bench for ar_rx_word: expected words and error codes are queued as stimulus is driven
// and popped when the receiver strobes ce_wr or err.
module tb_ar_rx_word;

  logic        clk = 1'b0;
  logic        res_n;
  logic        ce;
  logic        rxp, rxn;
  logic [31:0] dat;
  logic        ce_wr, par_ok, err;
  logic [7:0]  n_word;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  ar_rx_word #(.LABEL(8'hA5)) dut (
    .clk(clk), .res_n(res_n), .ce(ce), .RXP(rxp), .RXN(rxn),
    .dat(dat), .ce_wr(ce_wr), .par_ok(par_ok), .N_word(n_word),
    .err(err), .err_code(err_code)
  );

`ifdef AR_LABEL_FILT_EN
  localparam bit FILT_OFF = 1'b0;
`else
  localparam bit FILT_OFF = 1'b1;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_w[$];
  logic [2:0]  exp_e[$];
  logic [31:0] last_dat = 32'd0;
  logic [7:0]  nword_m = 8'd0;
  logic [7:0]  nword_final = 8'd0;
  logic [2:0]  last_code = 3'd0;
  logic [31:0] mon_w;
  logic [2:0]  mon_e;
  logic        mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic delivers(input logic [31:0] w);
    return FILT_OFF | (w[7:0] == 8'hA5);
  endfunction

  // One ce tick: level set at a negedge, ce pulsed three clocks later so the synchronizer has settled.
  task automatic hold(input logic p, input logic n, input int ticks);
    repeat (ticks) begin
      rxp = p;
      rxn = n;
      repeat (3) @(negedge clk);
      ce = 1'b1;
      @(negedge clk);
      ce = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [31:0] w, input int nb);
    for (int i = 0; i < nb; i++) begin
      hold(w[i], ~w[i], 4);
      hold(1'b0, 1'b0, 4);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    if (delivers(w)) begin
      exp_w.push_back(w);
      nword_final = nword_final + 8'd1;
    end
    send_bits(w, 32);
  endtask

  task automatic expect_err(input logic [2:0] code);
    exp_e.push_back(code);
    last_code = code;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ce_wr) begin
        chk("ce_wr_pending", 32'(exp_w.size() != 0), 32'd1);
        if (exp_w.size() != 0) begin
          mon_w = exp_w.pop_front();
          nword_m = nword_m + 8'd1;
          chk("dat", dat, mon_w);
          chk("par_ok", 32'(par_ok), 32'(^mon_w));
          chk("N_word", 32'(n_word), 32'(nword_m));
          last_dat = mon_w;
        end
      end
      if (err) begin
        chk("err_pending", 32'(exp_e.size() != 0), 32'd1);
        if (exp_e.size() != 0) begin
          mon_e = exp_e.pop_front();
          chk("err_code", 32'(err_code), 32'(mon_e));
          chk("dat_hold_on_err", dat, last_dat);
        end
      end
    end
  end

  initial begin
    res_n = 1'b0;
    ce    = 1'b0;
    rxp   = 1'b0;
    rxn   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dat", dat, 32'd0);
    chk("rst_ce_wr", 32'(ce_wr), 32'd0);
    chk("rst_par_ok", 32'(par_ok), 32'd0);
    chk("rst_N_word", 32'(n_word), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    res_n  = 1'b1;
    mon_en = 1'b1;

    // Initial gap, then two good words with odd and even parity.
    hold(1'b0, 1'b0, 30);
    send_word(32'h800000A5);
    hold(1'b0, 1'b0, 32);
    send_word(32'h000000A5);
    hold(1'b0, 1'b0, 32);

    // Truncated word followed by a clean one.
    expect_err(3'd4);
    send_bits(32'h000002D3, 10);
    hold(1'b0, 1'b0, 30);
    send_word(32'h12345678);
    hold(1'b0, 1'b0, 32);

    // Glitch pulse.
    send_bits(32'h00000015, 5);
    expect_err(3'd2);
    hold(1'b1, 1'b0, 1);
    hold(1'b0, 1'b0, 40);

    // Both comparators high.
    send_bits(32'h0000000A, 5);
    expect_err(3'd1);
    hold(1'b1, 1'b1, 2);
    hold(1'b0, 1'b0, 40);

    // Stuck pulse.
    send_bits(32'h0000001B, 5);
    expect_err(3'd5);
    hold(1'b1, 1'b0, 8);
    hold(1'b0, 1'b0, 40);

    // Short null between bits.
    send_bits(32'h00000011, 5);
    expect_err(3'd3);
    hold(1'b1, 1'b0, 4);
    hold(1'b0, 1'b0, 1);
    hold(1'b1, 1'b0, 4);
    hold(1'b0, 1'b0, 40);

    // Back-to-back words with an 8-tick null: first stands, second is discarded.
    send_word(32'hCAFE00A5);
    expect_err(3'd6);
    hold(1'b0, 1'b0, 4);
    send_bits(32'h0F0F0F0F, 32);
    hold(1'b0, 1'b0, 40);

    // Label mismatch word: delivered only when the filter is disabled.
    send_word(32'h0000005A);
    hold(1'b0, 1'b0, 32);

    repeat (10) @(negedge clk);
    chk("words_outstanding", 32'(exp_w.size()), 32'd0);
    chk("errs_outstanding", 32'(exp_e.size()), 32'd0);
    chk("N_word_final", 32'(n_word), 32'(nword_final));
    chk("err_code_held", 32'(err_code), 32'(last_code));
    chk("dat_final", dat, last_dat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
